// File: rtl/risc16_pkg.sv
// Shared definitions for the 16-bit RISC core front end.
//   fetch_state_e        : fetch FSM states (boot cycle, running, halted)
//   PC_STEP              : byte increment between sequential instructions
//   DEFAULT_HALT_OPCODE  : instruction encoding that stops fetch
//   DEFAULT_RESET_VECTOR : PC value loaded by reset
package risc16_pkg;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHalted
    } fetch_state_e;

    localparam logic [15:0] PC_STEP              = 16'd2;
    localparam logic [15:0] DEFAULT_HALT_OPCODE  = 16'hFFFF;
    localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h0000;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select for the fetch stage.
// Ports:
//   pc              in  16  current program counter
//   redirect        in  1   take redirect_target (highest priority)
//   redirect_target in  16  branch/jump target; bit 0 is forced to zero
//   hold            in  1   keep the current PC
//   next_pc         out 16  PC value for the next edge (16-bit modulo +2 otherwise)
module fetch_next_pc (
    input  logic [15:0] pc,
    input  logic        redirect,
    input  logic [15:0] redirect_target,
    input  logic        hold,
    output logic [15:0] next_pc
);

    import risc16_pkg::*;

    always_comb begin
        next_pc = pc + PC_STEP;
        if (redirect) begin
            // Instructions are halfword aligned; an odd target is rounded down.
            next_pc = redirect_target & 16'hFFFE;
        end else if (hold) begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, instruction memory address and IF/ID register.
// Optional feature macro: FETCH_PERF_CNT_EN builds the delivered-instruction counter;
// without it fetch_count reads as zero.
// Ports:
//   clk, rst         core clock, asynchronous active-high reset
//   stall            hold PC and IF/ID register
//   flush            invalidate IF/ID register (PC still advances unless stalled)
//   redirect         load PC from redirect_target (ignored in the boot cycle)
//   redirect_target  branch/jump target byte address
//   resume           leave the halted state
//   im_addr          byte address to instruction memory (equals PC)
//   im_data          instruction returned combinationally for im_addr
//   if_id_instr      captured instruction
//   if_id_pc         address of if_id_instr
//   if_id_valid      IF/ID register holds a real instruction
//   halted           fetch is halted
//   fetch_count      number of instructions delivered with valid=1
module instruction_fetch #(
    parameter logic [15:0] RESET_VECTOR = risc16_pkg::DEFAULT_RESET_VECTOR,
    parameter logic [15:0] HALT_OPCODE  = risc16_pkg::DEFAULT_HALT_OPCODE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [15:0] redirect_target,
    input  logic        resume,
    output logic [15:0] im_addr,
    input  logic [15:0] im_data,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    import risc16_pkg::*;

    fetch_state_e state_q;
    logic [15:0]  pc_q;
    logic [15:0]  instr_q;
    logic [15:0]  ifpc_q;
    logic         valid_q;
    logic         halted_q;

    logic         in_run;
    logic         redirect_en;
    logic         halt_seen;
    logic         hold_pc;
    logic         capture;
    logic [15:0]  pc_d;

    always_comb begin
        in_run      = (state_q == StRun);
        redirect_en = redirect && (state_q != StBoot);
        // A halt takes effect on the edge after it lands in IF/ID, so the PC
        // has already stepped past it and stays there while halted.
        halt_seen   = valid_q && (instr_q == HALT_OPCODE);
        hold_pc     = !in_run || stall || (!flush && halt_seen);
        capture     = in_run && !redirect && !flush && !stall && !halt_seen;
    end

    fetch_next_pc u_next_pc (
        .pc              (pc_q),
        .redirect        (redirect_en),
        .redirect_target (redirect_target),
        .hold            (hold_pc),
        .next_pc         (pc_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StBoot;
            pc_q     <= RESET_VECTOR;
            instr_q  <= 16'h0000;
            ifpc_q   <= 16'h0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (capture) begin
                instr_q <= im_data;
                ifpc_q  <= pc_q;
            end
            case (state_q)
                StBoot: begin
                    valid_q <= 1'b0;
                    state_q <= StRun;
                end
                StRun: begin
                    if (redirect || flush) begin
                        valid_q <= 1'b0;
                    end else if (stall) begin
                        valid_q <= valid_q;
                    end else if (halt_seen) begin
                        valid_q  <= 1'b0;
                        state_q  <= StHalted;
                        halted_q <= 1'b1;
                    end else begin
                        valid_q <= 1'b1;
                    end
                end
                StHalted: begin
                    valid_q <= 1'b0;
                    if (redirect || resume) begin
                        state_q  <= StRun;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StBoot;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] count_q;

    // Counts every edge that writes valid=1 into IF/ID; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 32'd0;
        end else if (capture) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = 32'd0;
`endif

    assign im_addr     = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = ifpc_q;
    assign if_id_valid = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [15:0] redirect_target;
    logic        resume;
    logic [15:0] im_addr;
    logic [15:0] im_data;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic [15:0] halt_addr;
    int checks;
    int errors;

    instruction_fetch u_dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .resume          (resume),
        .im_addr         (im_addr),
        .im_data         (im_data),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_valid     (if_id_valid),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: fixed words at 0 and 2, a movable halt word, otherwise addr ^ 0xA500.
    always_comb begin
        if (im_addr == halt_addr)      im_data = 16'hFFFF;
        else if (im_addr == 16'h0000)  im_data = 16'h1234;
        else if (im_addr == 16'h0002)  im_data = 16'h5678;
        else                           im_data = im_addr ^ 16'hA500;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        redirect_target = 16'h0000; resume = 1'b0; halt_addr = 16'h0001;
        #1 rst = 1'b1;
        #1;
        checks++; if (im_addr !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", im_addr); end
        checks++; if (if_id_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_flags: got valid=%b halted=%b want 0 0", if_id_valid, halted); end
        checks++; if (if_id_instr !== 16'h0 || if_id_pc !== 16'h0 || fetch_count !== 32'd0) begin errors++; $display("FAIL reset_regs: got %h %h %0d want 0 0 0", if_id_instr, if_id_pc, fetch_count); end
        @(posedge clk); #1 rst = 1'b0;
        step();
        checks++; if (if_id_valid !== 1'b0 || im_addr !== 16'h0000) begin errors++; $display("FAIL boot_cycle: got valid=%b pc=%h want 0 0000", if_id_valid, im_addr); end
        step();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h0000 || if_id_instr !== 16'h1234) begin errors++; $display("FAIL first_fetch: got %b %h %h want 1 0000 1234", if_id_valid, if_id_pc, if_id_instr); end
        step();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h0002 || if_id_instr !== 16'h5678) begin errors++; $display("FAIL second_fetch: got %b %h %h want 1 0002 5678", if_id_valid, if_id_pc, if_id_instr); end
    endtask

    task automatic test_stall();
        redirect = 1'b1; redirect_target = 16'h0010;
        step();
        redirect = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (im_addr !== 16'h0010 || if_id_valid !== 1'b0 || if_id_pc !== 16'h0002 || if_id_instr !== 16'h5678) begin
                errors++; $display("FAIL stall_hold[%0d]: got pc=%h valid=%b %h %h want 0010 0 0002 5678", i, im_addr, if_id_valid, if_id_pc, if_id_instr); end
        end
        stall = 1'b0;
        step();
        checks++; if (im_addr !== 16'h0012 || if_id_valid !== 1'b1 || if_id_pc !== 16'h0010 || if_id_instr !== 16'hA510) begin
            errors++; $display("FAIL stall_release: got pc=%h valid=%b %h %h want 0012 1 0010 A510", im_addr, if_id_valid, if_id_pc, if_id_instr); end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1; redirect = 1'b1; redirect_target = 16'h0101;
        step();
        checks++; if (im_addr !== 16'h0100 || if_id_valid !== 1'b0) begin errors++; $display("FAIL redirect_edge: got pc=%h valid=%b want 0100 0", im_addr, if_id_valid); end
        stall = 1'b0; redirect = 1'b0;
        step();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h0100 || if_id_instr !== 16'hA400) begin errors++; $display("FAIL redirect_target: got %b %h %h want 1 0100 A400", if_id_valid, if_id_pc, if_id_instr); end
    endtask

    task automatic test_halt();
        halt_addr = 16'h0020;
        redirect = 1'b1; redirect_target = 16'h0020;
        step();
        redirect = 1'b0;
        step();
        checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 16'hFFFF || if_id_pc !== 16'h0020 || halted !== 1'b0 || im_addr !== 16'h0022) begin
            errors++; $display("FAIL halt_deliver: got %b %h %h halted=%b pc=%h want 1 FFFF 0020 0 0022", if_id_valid, if_id_instr, if_id_pc, halted, im_addr); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (halted !== 1'b1 || if_id_valid !== 1'b0 || im_addr !== 16'h0022) begin
                errors++; $display("FAIL halted_hold[%0d]: got halted=%b valid=%b pc=%h want 1 0 0022", i, halted, if_id_valid, im_addr); end
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        checks++; if (halted !== 1'b0 || if_id_valid !== 1'b0 || im_addr !== 16'h0022) begin errors++; $display("FAIL resume_edge: got halted=%b valid=%b pc=%h want 0 0 0022", halted, if_id_valid, im_addr); end
        step();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h0022 || if_id_instr !== 16'hA522) begin errors++; $display("FAIL resume_fetch: got %b %h %h want 1 0022 A522", if_id_valid, if_id_pc, if_id_instr); end
        halt_addr = 16'h0001;
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_target = 16'hFFFE;
        step();
        redirect = 1'b0;
        step();
        checks++; if (im_addr !== 16'h0000 || if_id_pc !== 16'hFFFE || if_id_instr !== 16'h5AFE) begin errors++; $display("FAIL pc_wrap: got pc=%h %h %h want 0000 FFFE 5AFE", im_addr, if_id_pc, if_id_instr); end
    endtask

    task automatic test_flush_perf();
        int exp9;
        int exp10;
`ifdef FETCH_PERF_CNT_EN
        exp9 = 9; exp10 = 10;
`else
        exp9 = 0; exp10 = 0;
`endif
        step();
        step();
        rst = 1'b1;
        #1;
        checks++; if (im_addr !== 16'h0000 || if_id_valid !== 1'b0 || if_id_instr !== 16'h0 || if_id_pc !== 16'h0 || halted !== 1'b0 || fetch_count !== 32'd0) begin
            errors++; $display("FAIL async_reset: got pc=%h valid=%b %h %h halted=%b cnt=%0d want all zero", im_addr, if_id_valid, if_id_instr, if_id_pc, halted, fetch_count); end
        #2 rst = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            flush = (i == 4);
            step();
            if (i == 4) begin
                checks++; if (if_id_valid !== 1'b0 || im_addr !== 16'(2 * (i + 1))) begin errors++; $display("FAIL flush: got valid=%b pc=%h want 0 %h", if_id_valid, im_addr, 16'(2 * (i + 1))); end
            end else begin
                checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'(2 * i)) begin errors++; $display("FAIL burst[%0d]: got valid=%b pc=%h want 1 %h", i, if_id_valid, if_id_pc, 16'(2 * i)); end
            end
        end
        flush = 1'b0;
        checks++; if (fetch_count !== 32'(exp9)) begin errors++; $display("FAIL fetch_count: got %0d want %0d", fetch_count, exp9); end
        flush = 1'b1; stall = 1'b1;
        step();
        checks++; if (if_id_valid !== 1'b0 || im_addr !== 16'h0014 || fetch_count !== 32'(exp9)) begin errors++; $display("FAIL flush_stall: got valid=%b pc=%h cnt=%0d want 0 0014 %0d", if_id_valid, im_addr, fetch_count, exp9); end
        flush = 1'b0; stall = 1'b0;
        step();
        checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h0014 || fetch_count !== 32'(exp10)) begin errors++; $display("FAIL after_flush_stall: got valid=%b pc=%h cnt=%0d want 1 0014 %0d", if_id_valid, if_id_pc, fetch_count, exp10); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stall();
        test_redirect_stall();
        test_halt();
        test_wrap();
        test_flush_perf();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
